// File: rtl/csb_glb_arb_pkg.sv
// Shared definitions for the global-block CSB arbiter: request field positions,
// FSM encodings and request decode.
package csb_glb_arb_pkg;

   localparam int ADDR_LSB    = 0;
   localparam int ADDR_MSB    = 21;
   localparam int WDAT_LSB    = 22;
   localparam int WDAT_MSB    = 53;
   localparam int WRITE_BIT   = 54;
   localparam int NPOSTED_BIT = 55;
   localparam int SRCPRIV_BIT = 56;
   localparam int WRBE_LSB    = 57;
   localparam int WRBE_MSB    = 60;
   localparam int LEVEL_LSB   = 61;
   localparam int LEVEL_MSB   = 62;

   localparam int RESP_ID_BIT = 33;

   // Only the low bits up to nposted are needed to classify a request.
   localparam int DECODE_W = NPOSTED_BIT + 1;

   localparam logic [0:0] ST_ARB  = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // Reads and non-posted writes get a response; posted writes do not.
   function automatic logic expects_resp(input logic [DECODE_W-1:0] pd);
      return !pd[WRITE_BIT] || pd[NPOSTED_BIT];
   endfunction

endpackage

// File: rtl/csb_glb_owner_fifo.sv
// In-order FIFO of master IDs for requests still waiting on a response.
module csb_glb_owner_fifo
   import csb_glb_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read while counted as valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/csb_glb_arb.sv
// Round-robin arbiter sharing the global-block CSB port among NUM_REQ masters,
// routing each response back to the master that issued the matching request.
module csb_glb_arb
   import csb_glb_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int MAX_OUTST = 4,
   parameter int REQ_PD_W  = 63,
   parameter int RESP_PD_W = 34
) (
   input  logic                          autosa_core_clk,
   input  logic                          autosa_core_rst,
   input  logic [NUM_REQ-1:0]            req_pvld,
   output logic [NUM_REQ-1:0]            req_prdy,
   input  logic [NUM_REQ*REQ_PD_W-1:0]   req_pd,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [RESP_PD_W-1:0]          resp_pd,
   output logic                          csb2glb_req_pvld,
   input  logic                          csb2glb_req_prdy,
   output logic [REQ_PD_W-1:0]           csb2glb_req_pd,
   input  logic                          glb2csb_resp_valid,
   input  logic [RESP_PD_W-1:0]          glb2csb_resp_pd,
   output logic [$clog2(MAX_OUTST):0]    outst_cnt,
   output logic                          err_unexp_resp
);

   localparam int IDX_W = $clog2(NUM_REQ);

   // Handshakes: a request transfers on a cycle where valid and ready are both
   // high; valid and payload stay stable until then. Responses have no ready.
   logic [0:0]           state_q, state_d;
   logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;
   logic [REQ_PD_W-1:0]  send_pd_q, send_pd_d;
   logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
   logic [RESP_PD_W-1:0] resp_pd_q, resp_pd_d;
   logic                 err_q, err_d;

   logic [NUM_REQ-1:0]   elig;
   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   int                   scan_idx;
   logic [REQ_PD_W-1:0]  win_pd;
   logic                 grant;
   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [IDX_W-1:0]     fifo_head;

   // Eligibility looks at the registered occupancy only, so a same-cycle pop
   // never unblocks a grant early.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_pvld[i] &&
                   (!fifo_full || !expects_resp(req_pd[i*REQ_PD_W +: DECODE_W]));
      end
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = (int'(last_gnt_q) + k) % NUM_REQ;
         if (!win_found && elig[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(scan_idx);
         end
      end
   end

   assign win_pd    = req_pd[int'(win_idx)*REQ_PD_W +: REQ_PD_W];
   assign grant     = (state_q == ST_ARB) && win_found;
   assign fifo_push = grant && expects_resp(win_pd[DECODE_W-1:0]);
   assign fifo_pop  = glb2csb_resp_valid && !fifo_empty;

   always_comb begin
      state_d      = state_q;
      last_gnt_d   = last_gnt_q;
      send_pd_d    = send_pd_q;
      resp_valid_d = '0;
      resp_pd_d    = resp_pd_q;
      err_d        = err_q | (glb2csb_resp_valid && fifo_empty);
      if (grant) begin
         state_d    = ST_SEND;
         last_gnt_d = win_idx;
         send_pd_d  = win_pd;
      end else if ((state_q == ST_SEND) && csb2glb_req_prdy) begin
         state_d = ST_ARB;
      end
      if (fifo_pop) begin
         resp_valid_d = NUM_REQ'(1) << fifo_head;
         resp_pd_d    = glb2csb_resp_pd;
      end
   end

   always_ff @(posedge autosa_core_clk) begin
      if (autosa_core_rst) begin
         state_q      <= ST_ARB;
         last_gnt_q   <= IDX_W'(NUM_REQ - 1);
         send_pd_q    <= '0;
         resp_valid_q <= '0;
         resp_pd_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_gnt_q   <= last_gnt_d;
         send_pd_q    <= send_pd_d;
         resp_valid_q <= resp_valid_d;
         resp_pd_q    <= resp_pd_d;
         err_q        <= err_d;
      end
   end

   csb_glb_owner_fifo #(
      .DEPTH (MAX_OUTST),
      .W     (IDX_W)
   ) u_owner_fifo (
      .clk       (autosa_core_clk),
      .rst       (autosa_core_rst),
      .push      (fifo_push),
      .push_data (win_idx),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (outst_cnt)
   );

   assign req_prdy         = grant ? (NUM_REQ'(1) << win_idx) : '0;
   assign csb2glb_req_pvld = (state_q == ST_SEND);
   assign csb2glb_req_pd   = send_pd_q;
   assign resp_valid       = resp_valid_q;
   assign resp_pd          = resp_pd_q;
   assign err_unexp_resp   = err_q;

endmodule

// File: tb/tb_csb_glb_arb.sv
// Bench for csb_glb_arb: directed scenarios with literal checks, then random
// traffic compared every cycle against a queue-based transaction model.
module tb_csb_glb_arb;

   localparam int NUM_REQ   = 2;
   localparam int MAX_OUTST = 4;
   localparam int REQ_PD_W  = 63;
   localparam int RESP_PD_W = 34;
   localparam int CNT_W     = $clog2(MAX_OUTST) + 1;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic [NUM_REQ-1:0]          req_pvld = '0;
   logic [NUM_REQ-1:0]          req_prdy;
   logic [NUM_REQ*REQ_PD_W-1:0] req_pd = '0;
   logic [NUM_REQ-1:0]          resp_valid;
   logic [RESP_PD_W-1:0]        resp_pd;
   logic                        ds_pvld;
   logic                        ds_prdy = 1'b0;
   logic [REQ_PD_W-1:0]         ds_pd;
   logic                        up_rv = 1'b0;
   logic [RESP_PD_W-1:0]        up_rpd = '0;
   logic [CNT_W-1:0]            outst_cnt;
   logic                        err_unexp_resp;

   int n_checks = 0;
   int n_errors = 0;

   // clock / reset
   always #5 clk = ~clk;

   csb_glb_arb #(
      .NUM_REQ   (NUM_REQ),
      .MAX_OUTST (MAX_OUTST),
      .REQ_PD_W  (REQ_PD_W),
      .RESP_PD_W (RESP_PD_W)
   ) dut (
      .autosa_core_clk    (clk),
      .autosa_core_rst    (rst),
      .req_pvld           (req_pvld),
      .req_prdy           (req_prdy),
      .req_pd             (req_pd),
      .resp_valid         (resp_valid),
      .resp_pd            (resp_pd),
      .csb2glb_req_pvld   (ds_pvld),
      .csb2glb_req_prdy   (ds_prdy),
      .csb2glb_req_pd     (ds_pd),
      .glb2csb_resp_valid (up_rv),
      .glb2csb_resp_pd    (up_rpd),
      .outst_cnt          (outst_cnt),
      .err_unexp_resp     (err_unexp_resp)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // kind 0 = read, 1 = non-posted write, 2 = posted write
   function automatic logic [REQ_PD_W-1:0] mk_pd(input int kind);
      logic [REQ_PD_W-1:0] p;
      p = {$urandom, $urandom};
      p[54] = (kind != 0);
      p[55] = (kind == 1);
      return p;
   endfunction

   // ---------------- behavioural model + compare process ----------------
   int                   owner_q[$];
   logic                 m_busy;
   logic [REQ_PD_W-1:0]  m_pd;
   int                   m_last;
   logic                 m_err;
   logic [NUM_REQ-1:0]   m_rv;
   logic [RESP_PD_W-1:0] m_rpd;
   logic [NUM_REQ-1:0]   exp_prdy;
   int                   m_win;

   function automatic logic needs_resp(input logic [REQ_PD_W-1:0] p);
      return (p[54] == 1'b0) || (p[55] == 1'b1);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         owner_q.delete();
         m_busy = 1'b0;
         m_pd   = '0;
         m_last = NUM_REQ - 1;
         m_err  = 1'b0;
         m_rv   = '0;
         m_rpd  = '0;
      end else begin
         m_win = -1;
         if (!m_busy) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               int i;
               logic [REQ_PD_W-1:0] p;
               i = (m_last + k) % NUM_REQ;
               p = req_pd[i*REQ_PD_W +: REQ_PD_W];
               if (m_win < 0 && req_pvld[i] &&
                   (!needs_resp(p) || owner_q.size() < MAX_OUTST))
                  m_win = i;
            end
         end
         exp_prdy = (m_win >= 0) ? NUM_REQ'(1 << m_win) : '0;
         chk("req_prdy", 64'(req_prdy), 64'(exp_prdy));
         chk("ds_pvld", 64'(ds_pvld), 64'(m_busy));
         if (m_busy) chk("ds_pd", 64'(ds_pd), 64'(m_pd));
         chk("resp_valid", 64'(resp_valid), 64'(m_rv));
         if (m_rv != '0) chk("resp_pd", 64'(resp_pd), 64'(m_rpd));
         chk("outst_cnt", 64'(outst_cnt), 64'(owner_q.size()));
         chk("err_unexp", 64'(err_unexp_resp), 64'(m_err));
         // advance model one cycle
         m_rv = '0;
         if (up_rv) begin
            if (owner_q.size() > 0) begin
               m_rv  = NUM_REQ'(1 << owner_q.pop_front());
               m_rpd = up_rpd;
            end else begin
               m_err = 1'b1;
            end
         end
         if (m_win >= 0) begin
            m_pd   = req_pd[m_win*REQ_PD_W +: REQ_PD_W];
            m_last = m_win;
            m_busy = 1'b1;
            if (needs_resp(m_pd)) owner_q.push_back(m_win);
         end else if (m_busy && ds_prdy) begin
            m_busy = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] pv, input logic [REQ_PD_W-1:0] p0,
                        input logic [REQ_PD_W-1:0] p1, input logic dp,
                        input logic rv, input logic [RESP_PD_W-1:0] rpd);
      req_pvld = pv;
      req_pd   = {p1, p0};
      ds_prdy  = dp;
      up_rv    = rv;
      up_rpd   = rpd;
   endtask

   task automatic do_reset();
      drive(2'b00, '0, '0, 1'b0, 1'b0, '0);
      rst = 1'b1;
      cyc();
      @(negedge clk);
      chk("rst_prdy", 64'(req_prdy), 64'd0);
      chk("rst_pvld", 64'(ds_pvld), 64'd0);
      chk("rst_pd", 64'(ds_pd), 64'd0);
      chk("rst_rv", 64'(resp_valid), 64'd0);
      chk("rst_rpd", 64'(resp_pd), 64'd0);
      chk("rst_cnt", 64'(outst_cnt), 64'd0);
      chk("rst_err", 64'(err_unexp_resp), 64'd0);
      cyc();
      rst = 1'b0;
   endtask

   logic [REQ_PD_W-1:0]  p_a, p_b;
   logic [RESP_PD_W-1:0] r_a;
   int                   resp_pct;
   int                   prdy_pct;

   initial begin
      do_reset();

      // single read from master 0
      p_a = mk_pd(0);
      r_a = RESP_PD_W'({$urandom, $urandom});
      drive(2'b01, p_a, '0, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t1_prdy", 64'(req_prdy), 64'd1);
      cyc();
      drive(2'b00, '0, '0, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t1_pvld", 64'(ds_pvld), 64'd1);
      chk("t1_pd", 64'(ds_pd), 64'(p_a));
      chk("t1_cnt1", 64'(outst_cnt), 64'd1);
      cyc(); cyc(); cyc(); cyc();
      drive(2'b00, '0, '0, 1'b1, 1'b1, r_a);
      cyc();
      drive(2'b00, '0, '0, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t1_rv", 64'(resp_valid), 64'd1);
      chk("t1_rpd", 64'(resp_pd), 64'(r_a));
      chk("t1_cnt0", 64'(outst_cnt), 64'd0);
      cyc();

      // unexpected response sets sticky flag
      drive(2'b00, '0, '0, 1'b1, 1'b1, r_a);
      cyc();
      drive(2'b00, '0, '0, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t2_rv", 64'(resp_valid), 64'd0);
      chk("t2_err", 64'(err_unexp_resp), 64'd1);
      cyc(); cyc(); cyc();
      @(negedge clk);
      chk("t2_err_held", 64'(err_unexp_resp), 64'd1);
      cyc();
      do_reset();

      // backpressure: both masters request, downstream stalls 5 cycles
      p_a = mk_pd(0);
      p_b = mk_pd(0);
      drive(2'b11, p_a, p_b, 1'b0, 1'b0, '0);
      cyc();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_stall_prdy", 64'(req_prdy), 64'd0);
         chk("t3_stall_pd", 64'(ds_pd), 64'(p_a));
         cyc();
      end
      ds_prdy = 1'b1;
      cyc();
      @(negedge clk);
      chk("t3_next_gnt", 64'(req_prdy), 64'd2);
      cyc();
      do_reset();

      // fill to MAX_OUTST with master 0 reads
      for (int i = 0; i < MAX_OUTST; i++) begin
         drive(2'b01, mk_pd(0), '0, 1'b1, 1'b0, '0);
         cyc();
         drive(2'b00, '0, '0, 1'b1, 1'b0, '0);
         cyc();
      end
      drive(2'b10, '0, mk_pd(0), 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t4_full_cnt", 64'(outst_cnt), 64'(MAX_OUTST));
      chk("t4_read_stall", 64'(req_prdy), 64'd0);
      cyc();
      req_pvld = 2'b11;
      req_pd[0 +: REQ_PD_W] = mk_pd(2);
      @(negedge clk);
      chk("t4_posted_gnt", 64'(req_prdy), 64'd1);
      cyc();
      req_pvld = 2'b10;
      up_rv = 1'b1;
      cyc();
      up_rv = 1'b0;
      @(negedge clk);
      chk("t4_after_pop", 64'(req_prdy), 64'd2);
      cyc();
      do_reset();

      // same-cycle push and pop at outst_cnt = 2
      for (int i = 0; i < 2; i++) begin
         drive(2'b01, mk_pd(1), '0, 1'b1, 1'b0, '0);
         cyc();
         drive(2'b00, '0, '0, 1'b1, 1'b0, '0);
         cyc();
      end
      drive(2'b10, '0, mk_pd(0), 1'b1, 1'b1, r_a);
      @(negedge clk);
      chk("t5_gnt", 64'(req_prdy), 64'd2);
      cyc();
      drive(2'b00, '0, '0, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("t5_cnt", 64'(outst_cnt), 64'd2);
      chk("t5_rv", 64'(resp_valid), 64'd1);
      cyc();

      // randomized traffic, with a reset between segments
      for (int seg = 0; seg < 8; seg++) begin
         resp_pct = (seg % 4) * 20 + 5;
         prdy_pct = (seg % 3 == 0) ? 40 : 85;
         for (int c = 0; c < 500; c++) begin
            drive(2'($urandom_range(0, 3)),
                  mk_pd(int'($urandom_range(0, 2))),
                  mk_pd(int'($urandom_range(0, 2))),
                  ($urandom_range(0, 99) < prdy_pct),
                  ($urandom_range(0, 99) < resp_pct),
                  RESP_PD_W'({$urandom, $urandom}));
            cyc();
         end
         if (seg % 2 == 1) do_reset();
      end

      drive(2'b00, '0, '0, 1'b1, 1'b0, '0);
      cyc();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
